// File: rtl/led_fade_driver.sv
// led_fade_driver
// Turns a logical on/off LED pattern into active-low PWM pin drive. Each
// LED's duty ramps linearly (one count per fade step) toward its target.
// The target is the brightness ceiling when the LED is requested, else 0.
// The per-LED fade state is decoded from duty and target; it is not stored.
module led_fade_driver #(
   parameter int N_LED     = 8,
   parameter int PWM_BITS  = 8,
   parameter int STEP_LOG2 = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_LED-1:0]    pattern,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [N_LED-1:0]    led,
   output logic                busy
);

   typedef enum logic [1:0] {
      S_OFF     = 2'd0,
      S_RISING  = 2'd1,
      S_FALLING = 2'd2,
      S_ON      = 2'd3
   } fade_state_t;

   localparam logic [PWM_BITS-1:0]  DUTY_ONE = 1;
   localparam logic [STEP_LOG2-1:0] PS_ONE   = 1;

   logic [PWM_BITS-1:0]  pwm_cnt;
   logic [STEP_LOG2-1:0] prescaler;
   logic                 step_tick;

   logic [PWM_BITS-1:0]  duty     [N_LED];
   logic [PWM_BITS-1:0]  target   [N_LED];
   logic [PWM_BITS-1:0]  duty_nxt [N_LED];
   fade_state_t          state    [N_LED];
   logic [N_LED-1:0]     led_nxt;
   logic                 busy_nxt;

   // Decode each LED's target from the live inputs and classify its fade state.
   always_comb begin
      for (int i = 0; i < N_LED; i++) begin
         target[i] = pattern[i] ? brightness : '0;
         if (duty[i] < target[i])
            state[i] = S_RISING;
         else if (duty[i] > target[i])
            state[i] = S_FALLING;
         else if (duty[i] == '0)
            state[i] = S_OFF;
         else
            state[i] = S_ON;
      end
   end

   // Next duty (one step toward target on a step tick), pin drive and busy.
   always_comb begin
      step_tick = &prescaler;
      busy_nxt  = 1'b0;
      led_nxt   = '1;
      for (int i = 0; i < N_LED; i++) begin
         duty_nxt[i] = duty[i];
         if (step_tick) begin
            case (state[i])
               S_RISING:  duty_nxt[i] = duty[i] + DUTY_ONE;
               S_FALLING: duty_nxt[i] = duty[i] - DUTY_ONE;
               default:   duty_nxt[i] = duty[i];
            endcase
         end
         // Pins are active-low: emit while duty exceeds the PWM phase.
         led_nxt[i] = ~(duty[i] > pwm_cnt);
         if (state[i] == S_RISING || state[i] == S_FALLING)
            busy_nxt = 1'b1;
      end
   end

   // Counters, duty registers and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pwm_cnt   <= '0;
         prescaler <= '0;
         for (int i = 0; i < N_LED; i++)
            duty[i] <= '0;
         led  <= '1;
         busy <= 1'b0;
      end else begin
         pwm_cnt   <= pwm_cnt + DUTY_ONE;
         prescaler <= prescaler + PS_ONE;
         for (int i = 0; i < N_LED; i++)
            duty[i] <= duty_nxt[i];
         led  <= led_nxt;
         busy <= busy_nxt;
      end
   end

endmodule
